// File: rtl/regfile_param.sv
// Parametrised two-read / one-write register file with a hardware clear
// sequencer, optional hardwired zero register, optional write-to-read bypass
// and a read-valid strobe. Sits between decode and the ALU operand latches.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  input  logic              reg_read,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] dirA,
  input  logic [ADDR_W-1:0] dirB,
  input  logic [ADDR_W-1:0] dir_WR,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] datA,
  output logic [DATA_W-1:0] datB,
  output logic              rd_valid
);

  // Storage index only needs enough bits to reach DEPTH-1; the full address
  // is still range-checked so out-of-range accesses never touch storage.
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, next_state;
  logic [IDX_W-1:0]  clr_ptr, next_ptr;
  logic [DATA_W-1:0] regs [DEPTH];

  logic              idle;
  logic              wr_ok;
  logic              accept_wr;
  logic              accept_rd;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] value_a, value_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_X);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  function automatic logic [DATA_W-1:0] read_value(
    input logic [ADDR_W-1:0] addr,
    input logic              hit,
    input logic [DATA_W-1:0] fwd,
    input logic [DATA_W-1:0] stored
  );
    if (!in_range(addr) || is_zero_reg(addr)) return '0;
    if (hit) return fwd;
    return stored;
  endfunction

  // A clear request in IDLE wins over any read or write in the same cycle.
  assign idle      = (state == IDLE);
  assign busy      = (state == CLEAR);
  assign wr_ok     = reg_write && in_range(dir_WR) && !is_zero_reg(dir_WR);
  assign accept_wr = idle && !clear_req && wr_ok;
  assign accept_rd = idle && !clear_req && reg_read;
  assign hit_a     = (BYPASS != 0) && accept_wr && (dir_WR == dirA);
  assign hit_b     = (BYPASS != 0) && accept_wr && (dir_WR == dirB);
  assign value_a   = read_value(dirA, hit_a, data_in, regs[dirA[IDX_W-1:0]]);
  assign value_b   = read_value(dirB, hit_b, data_in, regs[dirB[IDX_W-1:0]]);

  // State register for the clear sequencer; reset restarts the clear at entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= next_state;
      clr_ptr <= next_ptr;
    end
  end

  // Next-state logic: walk every entry once, then idle until a clear request.
  always_comb begin
    next_state = state;
    next_ptr   = clr_ptr;
    case (state)
      CLEAR: begin
        if (clr_ptr == LAST_PTR) begin
          next_state = IDLE;
          next_ptr   = '0;
        end else begin
          next_ptr = clr_ptr + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          next_state = CLEAR;
          next_ptr   = '0;
        end
      end
      default: begin
        next_state = CLEAR;
        next_ptr   = '0;
      end
    endcase
  end

  // Storage update: clearing zeroes one entry per cycle, otherwise accepted writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        regs[clr_ptr] <= '0;
      end else if (accept_wr) begin
        regs[dir_WR[IDX_W-1:0]] <= data_in;
      end
    end
  end

  // Registered read ports and one-cycle valid strobe per accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      datA     <= '0;
      datB     <= '0;
      rd_valid <= 1'b0;
    end else if (accept_rd) begin
      datA     <= value_a;
      datB     <= value_b;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: three instances share one stimulus
// stream (default, no bypass, 12-entry) and are checked against hand values.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        reg_read;
  logic        reg_write;
  logic [3:0]  dirA, dirB, dir_WR;
  logic [31:0] data_in;

  logic        busy0, busy1, busy2;
  logic [31:0] datA0, datB0, datA1, datB1, datA2, datB2;
  logic        valid0, valid1, valid2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [3:0]  dir_wr;
    logic [31:0] din;
    logic        rd;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [31:0] ea0, eb0, ea1, eb1, ea2, eb2;
    logic        ev;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  regfile_param dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
    .reg_read(reg_read), .reg_write(reg_write), .dirA(dirA), .dirB(dirB),
    .dir_WR(dir_WR), .data_in(data_in), .datA(datA0), .datB(datB0),
    .rd_valid(valid0)
  );

  regfile_param #(.BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
    .reg_read(reg_read), .reg_write(reg_write), .dirA(dirA), .dirB(dirB),
    .dir_WR(dir_WR), .data_in(data_in), .datA(datA1), .datB(datB1),
    .rd_valid(valid1)
  );

  regfile_param #(.DEPTH(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy2),
    .reg_read(reg_read), .reg_write(reg_write), .dirA(dirA), .dirB(dirB),
    .dir_WR(dir_WR), .data_in(data_in), .datA(datA2), .datB(datB2),
    .rd_valid(valid2)
  );

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    clear_req = 1'b0;
    reg_read  = 1'b0;
    reg_write = 1'b0;
    dirA      = '0;
    dirB      = '0;
    dir_WR    = '0;
    data_in   = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reg_write = v.wr;
    dir_WR    = v.dir_wr;
    data_in   = v.din;
    reg_read  = v.rd;
    dirA      = v.a;
    dirB      = v.b;
    clear_req = 1'b0;
    cycle();
  endtask

  task automatic readBoth(input logic [3:0] a, input logic [3:0] b);
    idleInputs();
    reg_read = 1'b1;
    dirA     = a;
    dirB     = b;
    cycle();
    idleInputs();
  endtask

  initial begin
    int n0, n2, c;

    //                 wr dir  din           rd a  b   ea0           eb0           ea1           eb1           ea2           eb2           ev
    vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 1'b0, 4'd0,  4'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 4'd9,  32'h12345678, 1'b0, 4'd0,  4'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd5,  4'd9,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b1};
    vecs[3]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd0,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0};
    vecs[4]  = '{1'b1, 4'd3,  32'hA5A5A5A5, 1'b1, 4'd3,  4'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1};
    vecs[5]  = '{1'b1, 4'd0,  32'hFFFFFFFF, 1'b1, 4'd0,  4'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd0,  4'd3,  32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 1'b1};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd9,  4'd9,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b1};
    vecs[8]  = '{1'b1, 4'd15, 32'h0F0F0F0F, 1'b1, 4'd15, 4'd15, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 4'd1,  32'h0F0F0F0F, 32'h0,        32'h0F0F0F0F, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 4'd13, 32'h13131313, 1'b1, 4'd13, 4'd11, 32'h13131313, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd13, 4'd13, 32'h13131313, 32'h13131313, 32'h13131313, 32'h13131313, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd0,  32'h13131313, 32'h13131313, 32'h13131313, 32'h13131313, 32'h0,        32'h0,        1'b0};

    // Reset held for two edges, then the power-up clear.
    rst_n = 1'b0;
    idleInputs();
    @(negedge clk);
    cycle();
    cycle();
    checkOutput("reset_busy", 32'(busy0), 32'h1);
    checkOutput("reset_datA", datA0, 32'h0);
    checkOutput("reset_datB", datB0, 32'h0);
    checkOutput("reset_valid", 32'(valid0), 32'h0);

    rst_n = 1'b1;
    n0 = 0;
    n2 = 0;
    c  = 0;
    while ((busy0 || busy2) && c < 40) begin
      if (busy0) begin
        n0++;
        checkOutput("busy_datA", datA0, 32'h0);
      end
      if (busy2) n2++;
      c++;
      cycle();
    end
    checkOutput("init_busy_cycles", 32'(n0), 32'd16);
    checkOutput("init_busy_cycles_d12", 32'(n2), 32'd12);

    for (int i = 1; i < 16; i++) begin
      readBoth(4'(i), 4'(i));
      checkOutput("init_zero_A", datA0, 32'h0);
      checkOutput("init_zero_B", datB0, 32'h0);
    end

    // The reads above leave datA/datB at 0; table expectations start from there.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_datA", i), datA0, vecs[i].ea0);
      checkOutput($sformatf("vec%0d_datB", i), datB0, vecs[i].eb0);
      checkOutput($sformatf("vec%0d_datA_nobyp", i), datA1, vecs[i].ea1);
      checkOutput($sformatf("vec%0d_datB_nobyp", i), datB1, vecs[i].eb1);
      checkOutput($sformatf("vec%0d_datA_d12", i), datA2, vecs[i].ea2);
      checkOutput($sformatf("vec%0d_datB_d12", i), datB2, vecs[i].eb2);
      checkOutput($sformatf("vec%0d_valid", i), 32'(valid0), 32'(vecs[i].ev));
      checkOutput($sformatf("vec%0d_valid_nobyp", i), 32'(valid1), 32'(vecs[i].ev));
      checkOutput($sformatf("vec%0d_valid_d12", i), 32'(valid2), 32'(vecs[i].ev));
    end
    idleInputs();

    // Fill 1..15, then clear request with a colliding write and read.
    for (int i = 1; i < 16; i++) begin
      reg_write = 1'b1;
      dir_WR    = 4'(i);
      data_in   = 32'(i) * 32'h01010101;
      cycle();
    end
    readBoth(4'd7, 4'd4);
    checkOutput("fill_A7", datA0, 32'h07070707);
    checkOutput("fill_B4", datB0, 32'h04040404);

    clear_req = 1'b1;
    reg_write = 1'b1;
    dir_WR    = 4'd4;
    data_in   = 32'h44444444;
    reg_read  = 1'b1;
    dirA      = 4'd1;
    dirB      = 4'd2;
    cycle();
    checkOutput("clr_busy", 32'(busy0), 32'h1);
    checkOutput("clr_valid", 32'(valid0), 32'h0);
    checkOutput("clr_hold_A", datA0, 32'h07070707);
    idleInputs();

    n0 = 0;
    n2 = 0;
    c  = 0;
    while ((busy0 || busy2) && c < 40) begin
      if (busy0) n0++;
      if (busy2) n2++;
      clear_req = (c == 7);
      c++;
      cycle();
    end
    clear_req = 1'b0;
    checkOutput("clr_busy_cycles", 32'(n0), 32'd16);
    checkOutput("clr_busy_cycles_d12", 32'(n2), 32'd12);

    for (int i = 1; i < 16; i++) begin
      readBoth(4'(i), 4'(i));
      checkOutput("after_clr_A", datA0, 32'h0);
      checkOutput("after_clr_nobyp_B", datB1, 32'h0);
    end

    // Reset in the middle of a clear restarts the whole sequence.
    readBoth(4'd0, 4'd0);
    for (int i = 1; i < 16; i++) begin
      reg_write = 1'b1;
      dir_WR    = 4'(i);
      data_in   = 32'hC0000000 | 32'(i);
      cycle();
    end
    idleInputs();
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    for (int i = 1; i < 10; i++) cycle();
    checkOutput("mid_clr_busy", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    reg_write = 1'b1;
    dir_WR    = 4'd6;
    data_in   = 32'h66666666;
    n0 = 0;
    while (busy0 && n0 < 40) begin
      n0++;
      cycle();
    end
    idleInputs();
    checkOutput("rst_busy_cycles", 32'(n0), 32'd16);
    readBoth(4'd6, 4'd14);
    checkOutput("rst_write_ignored", datA0, 32'h0);
    checkOutput("rst_cleared_14", datB0, 32'h0);
    checkOutput("rst_write_ignored_nobyp", datA1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
